spi_reg_slave: RTL and testbench
================================

# spi_reg_slave

SPI mode-0 responder with a 16 × 8-bit register file, used as the far-end device for a master-configured `SPI_TOP`. It oversamples `SCK`, `SS` and `MOSI` on the system clock, decodes a command byte, then writes incoming bytes into the register file or returns register contents on `MISO`. The address auto-increments after every byte. A local port gives on-chip logic read access to the registers and a strobe for every SPI write.

## Interface
- `STATUS`, default `8'hA5`: byte shifted out on `MISO` during the command byte of every frame.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `SS` in 1: slave select from the master, active low, asynchronous to `clk`.
- `SCK` in 1: SPI clock from the master; CPOL=0, CPHA=0.
- `MOSI` in 1: serial data from the master, MSB first.
- `MISO` out 1: serial data to the master, MSB first.
- `MISO_oe` out 1: high while the synchronized `SS` is low; the top level tristates `MISO` when low.
- `loc_addr` in 4: local read address.
- `loc_data` out 8: registered `reg[loc_addr]`, one cycle latency.
- `wr_strobe` out 1: one-cycle pulse per committed SPI write.
- `wr_addr` out 4: address of the committed write, valid with `wr_strobe`.
- `wr_data` out 8: data of the committed write, valid with `wr_strobe`.
- `frame_done` out 1: one-cycle pulse when `SS` rises after at least one complete byte.

## Operation
- **Synchronizers:** two flops on each of `SS`, `SCK` and `MOSI`, plus one history flop on `SS` and `SCK` for edge detection. A rise or fall event is high for exactly one `clk` cycle.
- **States:**
  - IDLE: `SS` high.
  - CMD: byte 0 of the frame.
  - WRITE and READ: bytes 1 and later.
  - WAIT_SS: entered after reset if `SS` is already low. Leave only on `SS` high.
- **SS fall (IDLE→CMD):**
  - clear the 3-bit bit counter;
  - load the TX shift register with `STATUS`, so `MISO` = bit 7 before the first `SCK` rise.
- **SCK rise:**
  - shift the synchronized `MOSI` into the RX shift register and increment the bit counter (wraps mod 8).
  - When the counter wraps (8th bit), the byte is complete:
    - In CMD: bit 7 = 1 → WRITE, 0 → READ; `addr` = bits [3:0]; bits [6:4] are ignored.
    - In WRITE: `reg[addr]` ← byte; pulse `wr_strobe` with `wr_addr`/`wr_data` in the same cycle; `addr` ← `addr`+1 (15 wraps to 0).
    - In READ: `addr` ← `addr`+1 on the same rise that completes the byte.
- **SCK fall:**
  - If the counter is 0 (byte boundary), load the TX register:
    - READ: load `reg[addr]`, using the address in effect for the upcoming byte;
    - WRITE and CMD: load `8'h00`.
  - Otherwise shift the TX register left.
  - `MISO` is always TX bit 7.
- **SS rise:** any state → IDLE; discard a partial byte (no write, no strobe); pulse `frame_done` if at least one byte completed.
- **Local read:** `loc_data` ← `reg[loc_addr]` every cycle. If it coincides with an SPI write to the same address, it returns the old value.
- **Reset (`rst`=0 at a `clk` edge):**
  - all 16 registers = `8'h00`;
  - `MISO` = 0, `MISO_oe` = 0, `loc_data` = 0;
  - `wr_strobe`, `wr_addr`, `wr_data` and `frame_done` = 0;
  - `addr` = 0, bit counter = 0, TX and RX shift registers = 0;
  - synchronizer flops = idle level: `SS` stages 1, `SCK` stages 0.
  - Reset mid-frame: the block goes to WAIT_SS and ignores the rest of the frame.

## Timing
- Pin-to-event latency is 3 `clk` cycles (2 sync flops + edge flop).
- `MISO` changes 3 `clk` cycles after the `SCK` pin falls. `wr_strobe` fires 3 cycles after the 8th `SCK` pin rise.
- Required master timing:
  - `SCK` high time and low time each ≥ 4 `clk` periods;
  - `SS` fall to first `SCK` rise ≥ 4 `clk` periods;
  - last `SCK` fall to `SS` rise ≥ 4 `clk` periods.
  - This is met by `SPI_TOP` with `SPIBR_in` ≥ 2.
- The frame length is unbounded; the address keeps wrapping.

## Test plan
- **Reset:** reset → all outputs 0; `loc_addr` 0..15 each return `8'h00`; `MISO_oe`=0 while `SS` high.
- **Write with wrap:** frame `8'h8E`, `8'h11`, `8'h22`, `8'h33` → `reg[14]`=`8'h11`, `reg[15]`=`8'h22`, `reg[0]`=`8'h33`; three `wr_strobe` pulses with `wr_addr` 14, 15, 0; master receives `8'hA5`, `8'h00`, `8'h00`, `8'h00`; one `frame_done`.
- **Read with wrap:** after the write test, frame `8'h0E` + three dummy bytes → master receives `8'hA5`, `8'h11`, `8'h22`, `8'h33`; no `wr_strobe`.
- **Abort:**
  - frame `8'h83` + 5 bits of `8'hFF`, then `SS` high → `reg[3]` unchanged, no `wr_strobe`, `frame_done` pulses;
  - next frame `8'h03` + dummy → master receives the old `reg[3]`.
- **Reset mid-frame:** assert `rst` during the data byte of a write frame while `SS` stays low → no write; remaining bits ignored; a new frame after `SS` high works normally.
- **Collision:** `loc_addr`=5 held while SPI writes `8'h5A` to `reg[5]` → `loc_data` shows the old value in the strobe cycle, then `8'h5A` one cycle later.

Source files
------------

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register responder: 16 x 8-bit register file behind a
// command byte, auto-incrementing address, plus a local read port.
module spi_reg_slave #(
    parameter logic [7:0] STATUS = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_oe,
    input  logic [3:0] loc_addr,
    output logic [7:0] loc_data,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_READ,
        S_WAIT_SS
    } state_t;

    state_t      state_q;
    logic        ss_s1_q, ss_s2_q, ss_h_q;
    logic        sck_s1_q, sck_s2_q, sck_h_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic [1:0]  settle_q;
    logic [2:0]  bit_q;
    logic [6:0]  rx_q;
    logic [7:0]  tx_q;
    logic [3:0]  addr_q;
    logic        got_q;
    logic [7:0]  regs_q [16];
    logic        wr_strobe_q;
    logic [3:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        frame_done_q;
    logic [7:0]  loc_data_q;

    logic        ss_fall, ss_rise, sck_rise, sck_fall;
    logic [7:0]  rx_d;
    logic [3:0]  addr_d;

    assign ss_fall  = ss_h_q & ~ss_s2_q;
    assign ss_rise  = ~ss_h_q & ss_s2_q;
    assign sck_rise = ~sck_h_q & sck_s2_q;
    assign sck_fall = sck_h_q & ~sck_s2_q;
    assign rx_d     = {rx_q, mosi_s2_q};
    assign addr_d   = addr_q + 4'd1;

    assign MISO       = tx_q[7];
    assign MISO_oe    = ~ss_s2_q;
    assign loc_data   = loc_data_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_h_q    <= 1'b1;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_h_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            ss_s1_q   <= SS;
            ss_s2_q   <= ss_s1_q;
            ss_h_q    <= ss_s2_q;
            sck_s1_q  <= SCK;
            sck_s2_q  <= sck_s1_q;
            sck_h_q   <= sck_s2_q;
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Frame FSM, shift registers, register file writes and write strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            // WAIT_SS until the synchronizer reflects the real pin and SS
            // is high, so a frame already in progress is ignored.
            state_q      <= S_WAIT_SS;
            settle_q     <= 2'd0;
            bit_q        <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'h00;
            addr_q       <= 4'd0;
            got_q        <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_strobe_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            unique case (state_q)
                S_WAIT_SS: begin
                    if (settle_q >= 2'd2 && ss_s2_q) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (ss_fall) begin
                        state_q <= S_CMD;
                        bit_q   <= 3'd0;
                        tx_q    <= STATUS;
                        got_q   <= 1'b0;
                    end
                end
                default: begin
                    if (ss_rise) begin
                        state_q      <= S_IDLE;
                        frame_done_q <= got_q;
                    end else if (sck_rise) begin
                        rx_q  <= rx_d[6:0];
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            got_q <= 1'b1;
                            case (state_q)
                                S_CMD: begin
                                    state_q <= rx_d[7] ? S_WRITE : S_READ;
                                    addr_q  <= rx_d[3:0];
                                end
                                S_WRITE: begin
                                    regs_q[addr_q] <= rx_d;
                                    wr_strobe_q    <= 1'b1;
                                    wr_addr_q      <= addr_q;
                                    wr_data_q      <= rx_d;
                                    addr_q         <= addr_d;
                                end
                                default: begin
                                    addr_q <= addr_d;
                                end
                            endcase
                        end
                    end else if (sck_fall) begin
                        if (bit_q == 3'd0) begin
                            tx_q <= (state_q == S_READ) ? regs_q[addr_q]
                                                        : 8'h00;
                        end else begin
                            tx_q <= {tx_q[6:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    // Local read port; same-cycle SPI write is seen one cycle later
    always_ff @(posedge clk) begin
        if (!rst) begin
            loc_data_q <= 8'h00;
        end else begin
            loc_data_q <= regs_q[loc_addr];
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed testbench for spi_reg_slave: a bit-banged SPI mode-0 master
// with hand-computed expected bytes, strobes and register contents.
module tb_spi_reg_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       MISO_oe;
    logic [3:0] loc_addr;
    logic [7:0] loc_data;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_addr [$];
    logic [7:0] q_data [$];
    int         fd_cnt = 0;
    logic [7:0] ld_at_strobe = 8'h00;
    logic [7:0] ld_after = 8'h00;
    bit         pend = 0;

    spi_reg_slave #(.STATUS(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS        (SS),
        .SCK       (SCK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .MISO_oe   (MISO_oe),
        .loc_addr  (loc_addr),
        .loc_data  (loc_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Record write strobes, frame_done pulses and loc_data around strobes
    always @(negedge clk) begin
        if (pend) begin
            ld_after = loc_data;
            pend = 0;
        end
        if (wr_strobe) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            ld_at_strobe = loc_data;
            pend = 1;
        end
        if (frame_done) fd_cnt++;
    end

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        fd_cnt = 0;
    endtask

    task automatic ss_begin();
        @(negedge clk);
        SS = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_end();
        repeat (6) @(negedge clk);
        SS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            MOSI = b[i];
            repeat (6) @(negedge clk);
            r[i] = MISO;
            SCK = 1'b1;
            repeat (6) @(negedge clk);
            SCK = 1'b0;
        end
    endtask

    task automatic read_loc(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        loc_addr = a;
        @(negedge clk);
        d = loc_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b0;
        SS = 1'b1;
        SCK = 1'b0;
        MOSI = 1'b0;
        loc_addr = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({MISO, MISO_oe, wr_strobe, frame_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {MISO, MISO_oe, wr_strobe, frame_done});
        end
        checks++;
        if ({wr_addr, wr_data, loc_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000",
                     {wr_addr, wr_data, loc_data});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            read_loc(4'(a), d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %h want 00", a, d);
            end
        end
        checks++;
        if (MISO_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_oe_idle: got %b want 0", MISO_oe);
        end
    endtask

    task automatic test_write_wrap();
        logic [7:0] tx [4];
        logic [7:0] ex [4];
        logic [7:0] r;
        logic [7:0] d;
        tx = '{8'h8E, 8'h11, 8'h22, 8'h33};
        ex = '{8'hA5, 8'h00, 8'h00, 8'h00};
        clear_mon();
        ss_begin();
        checks++;
        if (MISO_oe !== 1'b1) begin
            errors++;
            $display("FAIL wr_oe: got %b want 1", MISO_oe);
        end
        for (int k = 0; k < 4; k++) begin
            spi_bits(tx[k], 8, r);
            checks++;
            if (r !== ex[k]) begin
                errors++;
                $display("FAIL wr_miso[%0d]: got %h want %h", k, r, ex[k]);
            end
        end
        ss_end();
        checks++;
        if (q_addr.size() != 3) begin
            errors++;
            $display("FAIL wr_nstrobe: got %0d want 3", q_addr.size());
        end else begin
            checks++;
            if ({q_addr[0], q_data[0], q_addr[1], q_data[1],
                 q_addr[2], q_data[2]} !== 36'hE11_F22_033) begin
                errors++;
                $display("FAIL wr_strobes: got %h %h %h %h %h %h want e 11 f 22 0 33",
                         q_addr[0], q_data[0], q_addr[1], q_data[1],
                         q_addr[2], q_data[2]);
            end
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL wr_frame_done: got %0d want 1", fd_cnt);
        end
        read_loc(4'd14, d);
        checks++;
        if (d !== 8'h11) begin
            errors++;
            $display("FAIL wr_reg14: got %h want 11", d);
        end
        read_loc(4'd15, d);
        checks++;
        if (d !== 8'h22) begin
            errors++;
            $display("FAIL wr_reg15: got %h want 22", d);
        end
        read_loc(4'd0, d);
        checks++;
        if (d !== 8'h33) begin
            errors++;
            $display("FAIL wr_reg0: got %h want 33", d);
        end
    endtask

    task automatic test_read_wrap();
        logic [7:0] tx [4];
        logic [7:0] ex [4];
        logic [7:0] r;
        tx = '{8'h0E, 8'h00, 8'h00, 8'h00};
        ex = '{8'hA5, 8'h11, 8'h22, 8'h33};
        clear_mon();
        ss_begin();
        for (int k = 0; k < 4; k++) begin
            spi_bits(tx[k], 8, r);
            checks++;
            if (r !== ex[k]) begin
                errors++;
                $display("FAIL rd_miso[%0d]: got %h want %h", k, r, ex[k]);
            end
        end
        ss_end();
        checks++;
        if (q_addr.size() != 0) begin
            errors++;
            $display("FAIL rd_nstrobe: got %0d want 0", q_addr.size());
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL rd_frame_done: got %0d want 1", fd_cnt);
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        logic [7:0] d;
        ss_begin();
        spi_bits(8'h83, 8, r);
        spi_bits(8'h3C, 8, r);
        ss_end();
        clear_mon();
        ss_begin();
        spi_bits(8'h83, 8, r);
        spi_bits(8'hFF, 5, r);
        ss_end();
        checks++;
        if (q_addr.size() != 0) begin
            errors++;
            $display("FAIL ab_nstrobe: got %0d want 0", q_addr.size());
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL ab_frame_done: got %0d want 1", fd_cnt);
        end
        read_loc(4'd3, d);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL ab_reg3: got %h want 3c", d);
        end
        ss_begin();
        spi_bits(8'h03, 8, r);
        checks++;
        if (r !== 8'hA5) begin
            errors++;
            $display("FAIL ab_status: got %h want a5", r);
        end
        spi_bits(8'h00, 8, r);
        checks++;
        if (r !== 8'h3C) begin
            errors++;
            $display("FAIL ab_readback: got %h want 3c", r);
        end
        ss_end();
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic [7:0] d;
        clear_mon();
        ss_begin();
        spi_bits(8'h87, 8, r);
        for (int i = 7; i > 4; i--) begin
            MOSI = 1'b1;
            repeat (6) @(negedge clk);
            SCK = 1'b1;
            repeat (6) @(negedge clk);
            SCK = 1'b0;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            MOSI = 1'b1;
            repeat (6) @(negedge clk);
            SCK = 1'b1;
            repeat (6) @(negedge clk);
            SCK = 1'b0;
        end
        spi_bits(8'hAB, 8, r);
        spi_bits(8'hCD, 8, r);
        ss_end();
        checks++;
        if (q_addr.size() != 0) begin
            errors++;
            $display("FAIL rm_nstrobe: got %0d want 0", q_addr.size());
        end
        checks++;
        if (fd_cnt != 0) begin
            errors++;
            $display("FAIL rm_frame_done: got %0d want 0", fd_cnt);
        end
        clear_mon();
        ss_begin();
        spi_bits(8'h87, 8, r);
        checks++;
        if (r !== 8'hA5) begin
            errors++;
            $display("FAIL rm_status: got %h want a5", r);
        end
        spi_bits(8'h77, 8, r);
        ss_end();
        checks++;
        if (q_addr.size() != 1) begin
            errors++;
            $display("FAIL rm_new_nstrobe: got %0d want 1", q_addr.size());
        end else begin
            checks++;
            if ({q_addr[0], q_data[0]} !== 12'h777) begin
                errors++;
                $display("FAIL rm_new_strobe: got %h %h want 7 77",
                         q_addr[0], q_data[0]);
            end
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL rm_new_frame_done: got %0d want 1", fd_cnt);
        end
        read_loc(4'd7, d);
        checks++;
        if (d !== 8'h77) begin
            errors++;
            $display("FAIL rm_reg7: got %h want 77", d);
        end
    endtask

    task automatic test_collision();
        logic [7:0] r;
        @(negedge clk);
        loc_addr = 4'd5;
        ss_begin();
        spi_bits(8'h85, 8, r);
        spi_bits(8'h11, 8, r);
        ss_end();
        clear_mon();
        ss_begin();
        spi_bits(8'h85, 8, r);
        spi_bits(8'h5A, 8, r);
        ss_end();
        checks++;
        if (q_addr.size() != 1) begin
            errors++;
            $display("FAIL col_nstrobe: got %0d want 1", q_addr.size());
        end
        checks++;
        if (ld_at_strobe !== 8'h11) begin
            errors++;
            $display("FAIL col_old: got %h want 11", ld_at_strobe);
        end
        checks++;
        if (ld_after !== 8'h5A) begin
            errors++;
            $display("FAIL col_new: got %h want 5a", ld_after);
        end
    endtask

    initial begin
        test_reset();
        test_write_wrap();
        test_read_wrap();
        test_abort();
        test_reset_mid();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
